// File: rtl/tetris_input.sv
// Command front-end for the game core: button edges, auto-repeat, gravity and
// garbage-bar requests are collected as pending bits and issued one at a time in WAIT.
package tetris_pkg;
   typedef enum logic [3:0] {
      NONE, INIT, WAIT, LEFT, RIGHT, DOWN, ROTATE, ROTATE_REV, DROP, HOLD, BAR, END
   } state_type;
endpackage

module tetris_input
   import tetris_pkg::*;
#(
   parameter int unsigned DAS_DELAY    = 20_000_000,
   parameter int unsigned ARR_PERIOD   = 5_000_000,
   parameter int unsigned GRAVITY_BASE = 100_000_000,
   parameter int unsigned GRAVITY_STEP = 9_000_000,
   parameter int unsigned BAR_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_down,
   input  logic        btn_rot,
   input  logic        btn_rot_rev,
   input  logic        btn_drop,
   input  logic        btn_hold,
   input  logic        bar_valid,
   input  logic [9:0]  bar_in,
   input  state_type   core_state,
   input  logic [15:0] score,
   output state_type   ctrl,
   output logic [9:0]  bar_mask,
   output logic [3:0]  level,
   output logic        bar_overflow
);

   localparam int unsigned DW = $clog2(DAS_DELAY + ARR_PERIOD + 1);
   localparam int unsigned GW = $clog2(GRAVITY_BASE + 1);
   localparam int unsigned AW = $clog2(BAR_DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam int unsigned P_LEFT    = 0;
   localparam int unsigned P_RIGHT   = 1;
   localparam int unsigned P_DOWN    = 2;
   localparam int unsigned P_ROT     = 3;
   localparam int unsigned P_ROT_REV = 4;
   localparam int unsigned P_DROP    = 5;
   localparam int unsigned P_HOLD    = 6;

   logic [6:0]          btn, rise, prev_q;
   logic [6:0]          pend_q, pend_d, set_v, clr_v;
   logic [2:0][DW-1:0]  das_q, das_d;
   logic [GW-1:0]       grav_q, grav_d;
   logic [31:0]         period;
   logic                grav_tick;
   logic [3:0]          level_q, level_d;
   logic                idle, flush, drop_issue, bar_issue;

   logic [9:0]          mem_q [BAR_DEPTH];
   logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic                ovf_q, ovf_d, bar_iss_q, bar_iss_d;
   logic                empty, full, push, pop, accept, bar_pend;

   always_comb begin
      btn   = {btn_hold, btn_drop, btn_rot_rev, btn_rot, btn_down, btn_right, btn_left};
      rise  = btn & ~prev_q;
      idle  = (core_state == INIT) || (core_state == END);
      flush = idle && (|rise);

      empty    = (wr_q == rd_q);
      full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      // BAR stays masked between its issue and the pop so one entry is issued once
      bar_pend = !empty && !bar_iss_q;
      push     = bar_valid && (bar_in != '0);
      pop      = (core_state == BAR) && !empty;
      accept   = push && (!full || pop);
      bar_mask = empty ? '0 : mem_q[rd_q[AW-1:0]];

      period    = 32'(GRAVITY_BASE) - 32'(level_q) * 32'(GRAVITY_STEP);
      grav_tick = (32'(grav_q) + 32'd1) >= period;
      level_d   = (score[15:8] != '0) ? 4'd10 : score[7:4];
   end

   always_comb begin
      ctrl       = NONE;
      clr_v      = '0;
      drop_issue = 1'b0;
      bar_issue  = 1'b0;
      if (reset) begin
         ctrl = NONE;
      end else if (core_state == WAIT) begin
         if (bar_pend) begin
            ctrl      = BAR;
            bar_issue = 1'b1;
         end else if (pend_q[P_DROP]) begin
            ctrl       = DROP;
            drop_issue = 1'b1;
            clr_v[P_DROP] = 1'b1;
            clr_v[P_DOWN] = 1'b1;
         end else if (pend_q[P_HOLD]) begin
            ctrl = HOLD;
            clr_v[P_HOLD] = 1'b1;
         end else if (pend_q[P_ROT]) begin
            ctrl = ROTATE;
            clr_v[P_ROT] = 1'b1;
         end else if (pend_q[P_ROT_REV]) begin
            ctrl = ROTATE_REV;
            clr_v[P_ROT_REV] = 1'b1;
         end else if (pend_q[P_LEFT]) begin
            ctrl = LEFT;
            clr_v[P_LEFT] = 1'b1;
         end else if (pend_q[P_RIGHT]) begin
            ctrl = RIGHT;
            clr_v[P_RIGHT] = 1'b1;
         end else if (pend_q[P_DOWN]) begin
            ctrl = DOWN;
            clr_v[P_DOWN] = 1'b1;
         end
      end else if (flush) begin
         ctrl = DOWN;
      end
   end

   always_comb begin
      set_v  = rise;
      das_d  = das_q;
      grav_d = grav_q;

      for (int unsigned i = 0; i < 3; i++) begin
         if (rise[i]) begin
            das_d[i] = '0;
         end else if (btn[i]) begin
            if ((das_q[i] == DW'(DAS_DELAY - 1)) ||
                (das_q[i] == DW'(DAS_DELAY + ARR_PERIOD - 1)))
               set_v[i] = 1'b1;
            das_d[i] = (das_q[i] == DW'(DAS_DELAY + ARR_PERIOD - 1)) ?
                       DW'(DAS_DELAY) : das_q[i] + DW'(1);
         end else begin
            das_d[i] = '0;
         end
      end

      // DROP restarts the gravity interval, so a tick on that same edge is discarded
      if (drop_issue) begin
         grav_d = '0;
      end else if (!idle) begin
         if (grav_tick) begin
            grav_d = '0;
            set_v[P_DOWN] = 1'b1;
         end else begin
            grav_d = grav_q + GW'(1);
         end
      end

      pend_d    = (pend_q & ~clr_v) | set_v;
      wr_d      = accept ? wr_q + PW'(1) : wr_q;
      rd_d      = pop ? rd_q + PW'(1) : rd_q;
      ovf_d     = ovf_q | (push && !accept);
      bar_iss_d = pop ? 1'b0 : (bar_iss_q | bar_issue);

      if (flush) begin
         pend_d    = '0;
         das_d     = '0;
         grav_d    = '0;
         wr_d      = '0;
         rd_d      = '0;
         ovf_d     = 1'b0;
         bar_iss_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q    <= '0;
         pend_q    <= '0;
         das_q     <= '0;
         grav_q    <= '0;
         level_q   <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         ovf_q     <= 1'b0;
         bar_iss_q <= 1'b0;
      end else begin
         prev_q    <= btn;
         pend_q    <= pend_d;
         das_q     <= das_d;
         grav_q    <= grav_d;
         level_q   <= level_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         ovf_q     <= ovf_d;
         bar_iss_q <= bar_iss_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && accept)
         mem_q[wr_q[AW-1:0]] <= bar_in;
   end

   assign level        = level_q;
   assign bar_overflow = ovf_q;

endmodule
